cache_arbiter: RTL and testbench



---
 rtl/cache_arbiter.sv | 118 +++++++++++
 tb/tb_cache_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between icache and dcache.
// The granted command is latched, so requesters may change their inputs once granted.
module cache_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  arb_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t                state_q;
    logic                  last_was_d_q;
    logic                  rd_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      wd_cnt_q;
    logic [CNT_W-1:0]      wd_cnt_d;
    logic                  timeout_q;

    logic i_req;
    logic d_req;
    logic pick_dcache;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;
    // On contention the side that did not win last time is served.
    assign pick_dcache = d_req & (~i_req | ~last_was_d_q);

    // Saturate so a long hang cannot wrap the watchdog back below the limit.
    assign wd_cnt_d = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_was_d_q <= 1'b1;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        wd_cnt_q <= '0;
                        if (pick_dcache) begin
                            state_q      <= GRANT_D;
                            last_was_d_q <= 1'b1;
                            addr_q       <= d_pmem_address;
                            wdata_q      <= d_pmem_wdata;
                            wr_q         <= d_pmem_write;
                            rd_q         <= ~d_pmem_write;
                        end else begin
                            state_q      <= GRANT_I;
                            last_was_d_q <= 1'b0;
                            addr_q       <= i_pmem_address;
                            wdata_q      <= '0;
                            wr_q         <= 1'b0;
                            rd_q         <= 1'b1;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    wd_cnt_q <= wd_cnt_d;
                    if (wd_cnt_d == CNT_MAX) begin
                        timeout_q <= 1'b1;
                    end
                    if (pmem_resp) begin
                        state_q <= RELEASE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign arb_timeout  = timeout_q;

    assign i_pmem_resp  = (state_q == GRANT_I) & pmem_resp;
    assign d_pmem_resp  = (state_q == GRANT_D) & pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: per-cycle vector table through a scoreboard queue,
// then hand sequences for alternation, watchdog and mid-transaction reset.
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          arb_timeout;

    cache_arbiter #(
        .ADDR_WIDTH    (AW),
        .LINE_WIDTH    (LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_pmem_read   (i_pmem_read),
        .i_pmem_address(i_pmem_address),
        .i_pmem_rdata  (i_pmem_rdata),
        .i_pmem_resp   (i_pmem_resp),
        .d_pmem_read   (d_pmem_read),
        .d_pmem_write  (d_pmem_write),
        .d_pmem_address(d_pmem_address),
        .d_pmem_wdata  (d_pmem_wdata),
        .d_pmem_rdata  (d_pmem_rdata),
        .d_pmem_resp   (d_pmem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .arb_timeout   (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          i_rd;
        logic [AW-1:0] i_addr;
        logic          d_rd;
        logic          d_wr;
        logic [AW-1:0] d_addr;
        logic [LW-1:0] d_wdata;
        logic          resp;
        logic [LW-1:0] rdata;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        logic          e_iresp;
        logic          e_dresp;
    } vec_t;

    typedef struct {
        logic          is_d;
        logic [AW-1:0] addr;
    } grant_t;

    vec_t   vecs[$];
    vec_t   sb_q[$];
    grant_t gnt_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    localparam logic [LW-1:0] LA5 = {32{8'hA5}};
    localparam logic [LW-1:0] W1  = {8{32'hDEADBEEF}};
    localparam logic [LW-1:0] W2  = {8{32'h12345678}};
    localparam logic [LW-1:0] R1  = {8{32'h0BADF00D}};
    localparam logic [LW-1:0] R3  = {8{32'hCAFEF00D}};

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic i_rd, input logic [AW-1:0] ia,
                       input logic d_rd, input logic d_wr, input logic [AW-1:0] da,
                       input logic [LW-1:0] dw, input logic resp, input logic [LW-1:0] rd,
                       input logic e_rd, input logic e_wr, input logic [AW-1:0] ea,
                       input logic [LW-1:0] ew, input logic e_ir, input logic e_dr);
        vec_t v;
        v.i_rd = i_rd; v.i_addr = ia; v.d_rd = d_rd; v.d_wr = d_wr; v.d_addr = da;
        v.d_wdata = dw; v.resp = resp; v.rdata = rd; v.e_rd = e_rd; v.e_wr = e_wr;
        v.e_addr = ea; v.e_wdata = ew; v.e_iresp = e_ir; v.e_dresp = e_dr;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 0; pmem_rdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        vec_t v;
        grant_t g;
        int wait_cnt;
        int done;
        int cyc;

        rst = 1;
        idle_inputs();

        // Simultaneous requests right after reset: icache first, then dcache write-back.
        add(1, 32'h100, 0, 1, 32'h200, W1, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(1, 32'h100, 0, 1, 32'h200, W1, 0, '0, 1, 0, 32'h100, '0, 0, 0);
        add(1, 32'h100, 0, 1, 32'h200, W1, 1, R1, 1, 0, 32'h100, '0, 1, 0);
        add(0, 32'h0,   0, 1, 32'h200, W1, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   0, 1, 32'h200, W1, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   0, 1, 32'h200, W1, 0, '0, 0, 1, 32'h200, W1, 0, 0);
        add(0, 32'h0,   0, 1, 32'h200, W1, 1, R1, 0, 1, 32'h200, W1, 0, 1);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        // Read and write both high: write wins; resp during RELEASE ignored.
        add(0, 32'h0,   1, 1, 32'h400, W2, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   1, 1, 32'h400, W2, 0, '0, 0, 1, 32'h400, W2, 0, 0);
        add(0, 32'h0,   1, 1, 32'h400, W2, 0, '0, 0, 1, 32'h400, W2, 0, 0);
        add(0, 32'h0,   1, 1, 32'h400, W2, 1, R1, 0, 1, 32'h400, W2, 0, 1);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 1, R1, 0, 0, 32'h0,   '0, 0, 0);
        // Dcache address changes mid-grant; latched 0x300 must hold.
        add(0, 32'h0,   1, 0, 32'h300, '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   1, 0, 32'h340, '0, 0, '0, 1, 0, 32'h300, '0, 0, 0);
        add(0, 32'h0,   1, 0, 32'h340, '0, 0, '0, 1, 0, 32'h300, '0, 0, 0);
        add(0, 32'h0,   1, 0, 32'h340, '0, 1, R3, 1, 0, 32'h300, '0, 0, 1);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 1, R3, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 1, R3, 0, 0, 32'h0,   '0, 0, 0);
        // Lone icache read of 0x60, response on the fifth grant cycle.
        add(1, 32'h60,  0, 0, 32'h0,   '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        for (int k = 0; k < 4; k++)
            add(1, 32'h60, 0, 0, 32'h0, '0, 0, '0, 1, 0, 32'h60, '0, 0, 0);
        add(1, 32'h60,  0, 0, 32'h0,   '0, 1, LA5, 1, 0, 32'h60, '0, 1, 0);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        // Icache drops its request mid-grant; transaction still completes.
        add(1, 32'h500, 0, 0, 32'h0,   '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 0, '0, 1, 0, 32'h500, '0, 0, 0);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 1, R3, 1, 0, 32'h500, '0, 1, 0);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);
        add(0, 32'h0,   0, 0, 32'h0,   '0, 0, '0, 0, 0, 32'h0,   '0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset_pmem_read",  {255'b0, pmem_read},   '0);
        chk("reset_pmem_write", {255'b0, pmem_write},  '0);
        chk("reset_i_resp",     {255'b0, i_pmem_resp}, '0);
        chk("reset_d_resp",     {255'b0, d_pmem_resp}, '0);
        chk("reset_timeout",    {255'b0, arb_timeout}, '0);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            rst = 0;
            v = vecs[k];
            i_pmem_read = v.i_rd; i_pmem_address = v.i_addr;
            d_pmem_read = v.d_rd; d_pmem_write = v.d_wr;
            d_pmem_address = v.d_addr; d_pmem_wdata = v.d_wdata;
            pmem_resp = v.resp; pmem_rdata = v.rdata;
            sb_q.push_back(v);
            @(negedge clk);
            v = sb_q.pop_front();
            chk($sformatf("v%0d_pmem_read", k),  {255'b0, pmem_read},   {255'b0, v.e_rd});
            chk($sformatf("v%0d_pmem_write", k), {255'b0, pmem_write},  {255'b0, v.e_wr});
            chk($sformatf("v%0d_i_resp", k),     {255'b0, i_pmem_resp}, {255'b0, v.e_iresp});
            chk($sformatf("v%0d_d_resp", k),     {255'b0, d_pmem_resp}, {255'b0, v.e_dresp});
            chk($sformatf("v%0d_timeout", k),    {255'b0, arb_timeout}, '0);
            if (v.e_rd || v.e_wr) begin
                chk($sformatf("v%0d_addr", k),  {224'b0, pmem_address}, {224'b0, v.e_addr});
                chk($sformatf("v%0d_wdata", k), pmem_wdata, v.e_wdata);
            end
            if (v.e_iresp) chk($sformatf("v%0d_i_rdata", k), i_pmem_rdata, v.rdata);
            if (v.e_dresp) chk($sformatf("v%0d_d_rdata", k), d_pmem_rdata, v.rdata);
        end

        // Both caches request continuously: six grants must alternate I,D,I,D,I,D.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            g.is_d = (k % 2 == 1);
            g.addr = g.is_d ? 32'h2000 : 32'h1000;
            gnt_q.push_back(g);
        end
        i_pmem_read = 1; i_pmem_address = 32'h1000;
        d_pmem_read = 1; d_pmem_address = 32'h2000;
        pmem_rdata = R1;
        wait_cnt = 0;
        done = 0;
        cyc = 0;
        while (done < 6 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (pmem_read || pmem_write) begin
                wait_cnt++;
                pmem_resp = (wait_cnt >= 3);
            end else begin
                wait_cnt = 0;
                pmem_resp = 0;
            end
            @(negedge clk);
            if (pmem_resp) begin
                g = gnt_q.pop_front();
                chk($sformatf("alt%0d_d_resp", done), {255'b0, d_pmem_resp}, {255'b0, g.is_d});
                chk($sformatf("alt%0d_i_resp", done), {255'b0, i_pmem_resp}, {255'b0, ~g.is_d});
                chk($sformatf("alt%0d_addr", done),   {224'b0, pmem_address}, {224'b0, g.addr});
                done++;
            end
        end
        if (done < 6) begin
            n_vec++;
            n_err++;
            $display("FAIL alternation_budget: got %0d grants expected 6", done);
        end
        #1 pmem_resp = 0;

        // Memory never answers: watchdog must trip after TO grant cycles and stick.
        do_reset();
        i_pmem_read = 1; i_pmem_address = 32'h700;
        for (int gc = 1; gc <= 20; gc++) begin
            @(posedge clk); #1;
            if (gc == 2) i_pmem_read = 0;
            @(negedge clk);
            chk($sformatf("wd%0d_pmem_read", gc), {255'b0, pmem_read},   {255'b0, 1'b1});
            chk($sformatf("wd%0d_timeout", gc),   {255'b0, arb_timeout}, {255'b0, gc >= TO + 1});
        end
        @(posedge clk); #1;
        pmem_resp = 1; pmem_rdata = LA5;
        @(negedge clk);
        chk("wd_late_i_resp",  {255'b0, i_pmem_resp}, {255'b0, 1'b1});
        chk("wd_late_timeout", {255'b0, arb_timeout}, {255'b0, 1'b1});
        @(posedge clk); #1;
        pmem_resp = 0;
        @(negedge clk);
        chk("wd_release_read",    {255'b0, pmem_read},   '0);
        chk("wd_release_timeout", {255'b0, arb_timeout}, {255'b0, 1'b1});

        // Reset while granted abandons the op and clears the sticky flag.
        @(posedge clk); #1;
        i_pmem_read = 1; i_pmem_address = 32'h740;
        @(posedge clk); #1;
        i_pmem_read = 0;
        @(negedge clk);
        chk("rst_mid_granted", {255'b0, pmem_read}, {255'b0, 1'b1});
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        pmem_resp = 1;
        @(negedge clk);
        chk("rst_mid_pmem_read", {255'b0, pmem_read},   '0);
        chk("rst_mid_i_resp",    {255'b0, i_pmem_resp}, '0);
        chk("rst_mid_timeout",   {255'b0, arb_timeout}, '0);
        @(posedge clk); #1;
        pmem_resp = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
